// File: rtl/gather_bus_pkg.sv
// gather_bus_pkg: shared widths and {valid, tag, value} field positions for the multicast/gather buses
package gather_bus_pkg;
    localparam int MASTER_NUMS_DEF = 14;
    localparam int ID_LEN_DEF = 5;
    localparam int VALUE_LEN_DEF = 32;
    localparam int TAG_LSB = VALUE_LEN_DEF;
    localparam int VALID_BIT = VALUE_LEN_DEF + ID_LEN_DEF;
    localparam int WORD_LEN = VALUE_LEN_DEF + ID_LEN_DEF + 1;
endpackage

// File: rtl/gather_bus_rr_arbiter.sv
// rr_arbiter: picks the first requester at or above ptr, wrapping modulo N
module rr_arbiter #(
    parameter int N = 14,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);
    logic [PW:0] s;
    // Walk the requesters starting at ptr; the first hit wins
    always_comb begin
        grant = '0;
        idx = '0;
        any = 1'b0;
        s = '0;
        for (int i = 0; i < N; i++) begin
            s = {1'b0, ptr} + (PW+1)'(i);
            s = (s >= (PW+1)'(N)) ? s - (PW+1)'(N) : s;
            if (!any && req[s[PW-1:0]]) begin
                any = 1'b1;
                idx = s[PW-1:0];
                grant[s[PW-1:0]] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/gather_bus.sv
// gather_bus: round-robin gather of one PE row onto a single tagged, registered output slot
module gather_bus
    import gather_bus_pkg::*;
#(
    parameter int MASTER_NUMS = MASTER_NUMS_DEF,
    parameter int ID_LEN = ID_LEN_DEF,
    parameter int VALUE_LEN = VALUE_LEN_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [MASTER_NUMS-1:0][VALUE_LEN:0] master_enable_data,
    output logic [MASTER_NUMS-1:0]              master_ready,
    output logic [VALUE_LEN+ID_LEN:0]           enable_tag_value,
    input  logic                                ready,
    input  logic                                set_id,
    input  logic [ID_LEN-1:0]                   id_scan_in,
    output logic [ID_LEN-1:0]                   id_scan_out
);
    localparam int PW = $clog2(MASTER_NUMS);
    logic [MASTER_NUMS-1:0][ID_LEN-1:0] id_reg;
    logic [MASTER_NUMS-1:0] req, grant;
    logic [PW-1:0] rr_ptr, idx;
    logic any, out_valid, grant_en;
    logic [ID_LEN-1:0] out_tag;
    logic [VALUE_LEN-1:0] out_value;
    // Requests are the valid bits of each PE's {valid, value} word
    always_comb begin
        req = '0;
        for (int i = 0; i < MASTER_NUMS; i++) req[i] = master_enable_data[i][VALUE_LEN];
    end
    rr_arbiter #(.N(MASTER_NUMS)) u_arb (
        .req(req),
        .ptr(rr_ptr),
        .grant(grant),
        .idx(idx),
        .any(any)
    );
    assign grant_en = !rst && (!out_valid || ready) && !set_id && any;
    assign master_ready = grant_en ? grant : '0;
    assign enable_tag_value = {out_valid, out_tag, out_value};
    assign id_scan_out = id_reg[MASTER_NUMS-1];
    // ID scan chain: a new ID enters PE0 and every register passes its ID to the next PE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) id_reg <= '0;
        else if (set_id) id_reg <= {id_reg[MASTER_NUMS-2:0], id_scan_in};
    end
    // Output slot and pointer: load on a grant, otherwise empty once the word is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_tag <= '0;
            out_value <= '0;
            rr_ptr <= '0;
        end else if (grant_en) begin
            out_valid <= 1'b1;
            out_tag <= id_reg[idx];
            out_value <= master_enable_data[idx][VALUE_LEN-1:0];
            rr_ptr <= (idx == PW'(MASTER_NUMS - 1)) ? '0 : idx + 1'b1;
        end else if (ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gather_bus.sv
// tb_gather_bus: directed stimulus checked against a queue-based behavioural model every cycle
module tb_gather_bus;
    import gather_bus_pkg::*;
    localparam int N = MASTER_NUMS_DEF;
    localparam int IL = ID_LEN_DEF;
    localparam int VL = VALUE_LEN_DEF;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ready = 1'b0;
    logic set_id = 1'b0;
    logic [N-1:0][VL:0] master_enable_data = '0;
    logic [N-1:0] master_ready;
    logic [VL+IL:0] enable_tag_value;
    logic [IL-1:0] id_scan_in = '0;
    logic [IL-1:0] id_scan_out;
    int checks = 0;
    int errors = 0;
    logic [VL-1:0] q [N][$];
    int m_id [N];
    bit m_valid;
    int m_tag;
    logic [VL-1:0] m_value;
    int m_ptr;
    int order [6] = '{2, 5, 13, 2, 5, 13};
    logic [VL+IL:0] got;

    always #5 clk = ~clk;

    gather_bus dut (
        .clk(clk),
        .rst(rst),
        .master_enable_data(master_enable_data),
        .master_ready(master_ready),
        .enable_tag_value(enable_tag_value),
        .ready(ready),
        .set_id(set_id),
        .id_scan_in(id_scan_in),
        .id_scan_out(id_scan_out)
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_grant();
        int k;
        if (rst || set_id || (m_valid && !ready)) return -1;
        for (int i = 0; i < N; i++) begin
            k = (m_ptr + i) % N;
            if (master_enable_data[k][VL]) return k;
        end
        return -1;
    endfunction

    function automatic logic [63:0] exp_word();
        logic [VL+IL:0] w;
        w = {m_valid, IL'(m_tag), m_value};
        return 64'(w);
    endfunction

    // Model: slot, rotating priority start and ID chain, updated from the rules each edge
    always @(posedge clk or posedge rst) begin : model_upd
        int g;
        if (rst) begin
            for (int i = 0; i < N; i++) m_id[i] = 0;
            m_valid = 0;
            m_tag = 0;
            m_value = '0;
            m_ptr = 0;
        end else begin
            g = exp_grant();
            if (set_id) begin
                for (int i = N - 1; i > 0; i--) m_id[i] = m_id[i-1];
                m_id[0] = int'(id_scan_in);
            end
            if (g >= 0) begin
                m_valid = 1;
                m_tag = m_id[g];
                m_value = master_enable_data[g][VL-1:0];
                m_ptr = (g + 1) % N;
            end else if (ready) begin
                m_valid = 0;
            end
        end
    end

    // Compare every cycle, midway between active edges
    always @(negedge clk) begin : compare
        int g;
        if (!rst) begin
            g = exp_grant();
            chk("master_ready", 64'(master_ready), (g >= 0) ? (64'(1) << g) : 64'(0));
            chk("enable_tag_value", 64'(enable_tag_value), exp_word());
            chk("id_scan_out", 64'(id_scan_out), 64'(m_id[N-1]));
        end
    end

    task automatic drive();
        for (int k = 0; k < N; k++)
            master_enable_data[k] = (q[k].size() != 0) ? {1'b1, q[k][0]} : '0;
    endtask

    // One clock: note handshakes before the edge, retire accepted words after it
    task automatic step();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = master_ready;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) if (hs[k]) void'(q[k].pop_front());
        drive();
        #1;
    endtask

    initial begin
        drive();
        #1 rst = 1'b1;
        #2;
        chk("rst_word", 64'(enable_tag_value), 64'(0));
        chk("rst_ready", 64'(master_ready), 64'(0));
        chk("rst_scan", 64'(id_scan_out), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        // Scan IDs 13..0 so PE k ends up with tag k
        set_id = 1'b1;
        for (int c = 0; c < N; c++) begin
            id_scan_in = IL'(N - 1 - c);
            step();
        end
        set_id = 1'b0;
        #1;
        chk("scan_out_13", 64'(id_scan_out), 64'(13));
        chk("model_id7", 64'(m_id[7]), 64'(7));
        // Round robin among PEs 2, 5, 13
        ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            q[2].push_back(32'h200 + 32'(n));
            q[5].push_back(32'h500 + 32'(n));
            q[13].push_back(32'hD00 + 32'(n));
        end
        drive();
        #1;
        for (int i = 0; i < 6; i++) begin
            step();
            got = enable_tag_value;
            chk("rr_valid", 64'(got[VALID_BIT]), 64'(1));
            chk("rr_tag", 64'(got[TAG_LSB +: IL]), 64'(order[i]));
            chk("rr_value", 64'(got[VL-1:0]), 64'(32'h100 * 32'(order[i]) + 32'(i / 3)));
        end
        step();
        chk("rr_idle", 64'(enable_tag_value[VALID_BIT]), 64'(0));
        // Single requester PE3
        q[3].push_back(32'hDEADBEEF);
        drive();
        #1;
        chk("single_ready", 64'(master_ready), 64'(14'h0008));
        step();
        chk("single_word", 64'(enable_tag_value), 64'({1'b1, 5'd3, 32'hDEADBEEF}));
        chk("single_ready_off", 64'(master_ready), 64'(0));
        step();
        chk("single_drop", 64'(enable_tag_value[VALID_BIT]), 64'(0));
        // Backpressure with PE0 holding a second word
        q[0].push_back(32'hA0A00001);
        q[0].push_back(32'hB0B00002);
        drive();
        #1;
        step();
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_ready", 64'(master_ready), 64'(0));
            chk("bp_hold", 64'(enable_tag_value), 64'({1'b1, 5'd0, 32'hA0A00001}));
            step();
        end
        ready = 1'b1;
        #1;
        chk("bp_release", 64'(master_ready), 64'(14'h0001));
        step();
        chk("bp_second", 64'(enable_tag_value), 64'({1'b1, 5'd0, 32'hB0B00002}));
        step();
        // set_id while PE1 requests and a word is pending
        q[0].push_back(32'h0000D00D);
        drive();
        #1;
        step();
        q[1].push_back(32'h0000E00E);
        set_id = 1'b1;
        id_scan_in = 5'd21;
        drive();
        #1;
        chk("setid_block", 64'(master_ready), 64'(0));
        step();
        chk("setid_drain", 64'(enable_tag_value[VALID_BIT]), 64'(0));
        id_scan_in = 5'd22;
        #1;
        chk("setid_block2", 64'(master_ready), 64'(0));
        step();
        set_id = 1'b0;
        #1;
        chk("model_id1", 64'(m_id[1]), 64'(21));
        chk("setid_grant", 64'(master_ready), 64'(14'h0002));
        step();
        chk("setid_word", 64'(enable_tag_value), 64'({1'b1, 5'd21, 32'h0000E00E}));
        // Asynchronous reset while the slot is full and others are requesting
        q[2].push_back(32'h0000F00F);
        drive();
        #1;
        step();
        q[4].push_back(32'h00004444);
        q[9].push_back(32'h00009999);
        drive();
        #1;
        rst = 1'b1;
        #1;
        chk("arst_word", 64'(enable_tag_value), 64'(0));
        chk("arst_ready", 64'(master_ready), 64'(0));
        chk("arst_scan", 64'(id_scan_out), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("arst_after", 64'(enable_tag_value[VALID_BIT]), 64'(0));
        chk("arst_ptr0", 64'(master_ready), 64'(14'h0010));
        step();
        chk("arst_pe4", 64'(enable_tag_value), 64'({1'b1, 5'd0, 32'h00004444}));
        step();
        chk("arst_pe9", 64'(enable_tag_value), 64'({1'b1, 5'd0, 32'h00009999}));
        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
